// File: rtl/it_alu.sv
// it_alu: handshaked integer ALU. Single-cycle ADD/SUB/AND/OR/NOT/XOR,
// iterative WIDTH-step signed MUL (shift-add) and DIV (restoring).
// The result is held in a DONE state until the consumer takes it.
module it_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] val_A,
  input  logic [WIDTH-1:0] val_B,
  input  logic [2:0]       ALU_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_out,
  output logic [31:0]      flags
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   step_cnt;
  logic               is_div;
  logic               neg_res;
  logic [WIDTH-1:0]   mag_m;    // multiplicand (MUL) or divisor (DIV) magnitude
  logic [WIDTH-1:0]   work_hi;  // product high half / partial remainder
  logic [WIDTH-1:0]   work_lo;  // multiplier bits / dividend-then-quotient bits

  // Unsigned magnitude of a two's-complement value; the most negative value
  // maps onto 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (-x) : x;
  endfunction

  function automatic logic [31:0] flag_word(input logic [WIDTH-1:0] res,
                                            input logic inv, input logic ovf);
    return {res[WIDTH-1], (res == '0), inv, ovf, 28'd0};
  endfunction

  // Single-cycle results, computed straight from the presented operands.
  logic [WIDTH-1:0] add_res, sub_res, simple_res;
  logic             simple_v;

  // Combinational result for the single-cycle operations.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    add_res    = val_A + val_B;
    sub_res    = val_A - val_B;
    simple_res = '0;
    simple_v   = 1'b0;
    case (ALU_op)
      OP_ADD: begin
        simple_res = add_res;
        simple_v   = (val_A[WIDTH-1] == val_B[WIDTH-1]) &&
                     (add_res[WIDTH-1] != val_A[WIDTH-1]);
      end
      OP_SUB: begin
        simple_res = sub_res;
        simple_v   = (val_A[WIDTH-1] != val_B[WIDTH-1]) &&
                     (sub_res[WIDTH-1] != val_A[WIDTH-1]);
      end
      OP_AND:  simple_res = val_A & val_B;
      OP_OR:   simple_res = val_A | val_B;
      OP_NOT:  simple_res = ~val_B;
      OP_XOR:  simple_res = val_A ^ val_B;
      default: simple_res = '0;
    endcase
  end

  // One iteration step of shift-add multiply or restoring divide.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;

  // Next working-register values for one BUSY cycle.
  always_comb begin
    mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag_m} : '0);
    div_sh  = {work_hi, work_lo[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, mag_m});
    div_sub = div_sh[WIDTH-1:0] - mag_m;
    if (is_div) begin
      nxt_hi = div_ge ? div_sub : div_sh[WIDTH-1:0];
      nxt_lo = {work_lo[WIDTH-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
    end
  end

  // Sign correction and flag derivation applied on the final step.
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0]   quo, iter_res;
  logic               div_zero, iter_v, iter_i;

  // Final result of the iterative operations from the last step's values.
  always_comb begin
    prod_mag = {nxt_hi, nxt_lo};
    prod     = neg_res ? (-prod_mag) : prod_mag;
    quo      = neg_res ? (-nxt_lo) : nxt_lo;
    div_zero = (mag_m == '0);
    iter_res = '0;
    iter_v   = 1'b0;
    iter_i   = 1'b0;
    if (is_div) begin
      iter_res = div_zero ? '0 : quo;
      iter_i   = div_zero;
      // Only MIN / -1 yields a positive quotient of magnitude 2^(WIDTH-1).
      iter_v   = !div_zero && !neg_res && nxt_lo[WIDTH-1];
    end else begin
      iter_res = prod[WIDTH-1:0];
      iter_v   = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
    end
  end

  // Control FSM with registered handshake outputs, result and datapath.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ALU_out   <= '0;
      flags     <= '0;
      step_cnt  <= '0;
      is_div    <= 1'b0;
      neg_res   <= 1'b0;
      mag_m     <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (ALU_op == OP_MUL || ALU_op == OP_DIV) begin
              is_div   <= (ALU_op == OP_DIV);
              neg_res  <= val_A[WIDTH-1] ^ val_B[WIDTH-1];
              mag_m    <= (ALU_op == OP_DIV) ? magnitude(val_B) : magnitude(val_A);
              work_lo  <= (ALU_op == OP_DIV) ? magnitude(val_A) : magnitude(val_B);
              work_hi  <= '0;
              step_cnt <= '0;
              state    <= BUSY;
            end else begin
              ALU_out   <= simple_res;
              flags     <= flag_word(simple_res, 1'b0, simple_v);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          work_hi  <= nxt_hi;
          work_lo  <= nxt_lo;
          step_cnt <= step_cnt + 1'b1;
          if (step_cnt == CNT_W'(WIDTH - 1)) begin
            ALU_out   <= iter_res;
            flags     <= flag_word(iter_res, iter_i, iter_v);
            out_valid <= 1'b1;
            step_cnt  <= '0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_it_alu.sv
// tb_it_alu: self-checking bench for it_alu at WIDTH=32. Directed corner
// vectors plus randomized operations checked against a 64-bit arithmetic
// reference model; handshake, backpressure and reset-abort scenarios.
module tb_it_alu;

  localparam int W = 32;
  localparam longint MAX_I = 64'sd2147483647;
  localparam longint MIN_I = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  val_A, val_B;
  logic [2:0]    ALU_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  ALU_out;
  logic [31:0]   flags;

  int errors = 0;
  int checks = 0;

  logic [31:0] corners [8] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                               32'h7FFF_FFFF, 32'h8000_0000, 32'h0001_0000,
                               32'h0000_0002, 32'hFFFF_FFFE};

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic [31:0] flg;
    int          lat;
  } vec_t;

  it_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .val_A     (val_A),
    .val_B     (val_B),
    .ALU_op    (ALU_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALU_out   (ALU_out),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Reference model: exact signed arithmetic in 64 bits, then truncate.
  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] op,
                                  output logic [31:0] res, output logic [31:0] flg);
    longint sa, sb, r;
    logic   inv, ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    r   = 0;
    inv = 1'b0;
    ovf = 1'b0;
    res = '0;
    case (op)
      3'd0: begin r = sa + sb; ovf = (r > MAX_I) || (r < MIN_I); res = r[31:0]; end
      3'd1: begin r = sa - sb; ovf = (r > MAX_I) || (r < MIN_I); res = r[31:0]; end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: begin r = sa * sb; ovf = (r > MAX_I) || (r < MIN_I); res = r[31:0]; end
      3'd5: begin
        if (sb == 0) begin
          inv = 1'b1;
          res = '0;
        end else begin
          r   = sa / sb;
          ovf = (r > MAX_I);
          res = r[31:0];
        end
      end
      3'd6: res = ~b;
      default: res = a ^ b;
    endcase
    flg = {res[31], (res == 32'd0), inv, ovf, 28'd0};
  endfunction

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  // Present one operation, scramble inputs after acceptance, and wait
  // (bounded) for out_valid. lat counts edges from acceptance to the edge
  // at which out_valid is first seen high.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       output logic [31:0] res, output logic [31:0] flg, output int lat);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
    end
    val_A    = a;
    val_B    = b;
    ALU_op   = op;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    val_A    = $urandom;
    val_B    = $urandom;
    ALU_op   = 3'($urandom);
    lat      = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = ALU_out;
    flg = flags;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    checks++;
    if (ALU_out !== 32'd0 || flags !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: ALU_out=%h flags=%h required 0/0", ALU_out, flags);
    end
  endtask

  task automatic test_directed();
    vec_t        v[$];
    logic [31:0] res, flg;
    int          lat;
    v.push_back('{"add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 3'd0, 32'h8000_0000, 32'h9000_0000, 1});
    v.push_back('{"sub_ovf",   32'h8000_0000, 32'h0000_0001, 3'd1, 32'h7FFF_FFFF, 32'h1000_0000, 1});
    v.push_back('{"and_zero",  32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'd2, 32'h0000_0000, 32'h4000_0000, 1});
    v.push_back('{"or_mix",    32'h1234_0000, 32'h0000_5678, 3'd3, 32'h1234_5678, 32'h0000_0000, 1});
    v.push_back('{"not_b",     32'h1111_1111, 32'h0000_0000, 3'd6, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    v.push_back('{"xor_self",  32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'd7, 32'h0000_0000, 32'h4000_0000, 1});
    v.push_back('{"mul_neg",   32'hFFFF_FFFD, 32'h0000_0007, 3'd4, 32'hFFFF_FFEB, 32'h8000_0000, 33});
    v.push_back('{"mul_ovf",   32'h0001_0000, 32'h0001_0000, 3'd4, 32'h0000_0000, 32'h5000_0000, 33});
    v.push_back('{"div_neg",   32'hFFFF_FFF9, 32'h0000_0002, 3'd5, 32'hFFFF_FFFD, 32'h8000_0000, 33});
    v.push_back('{"div_zero",  32'h0000_0007, 32'h0000_0000, 3'd5, 32'h0000_0000, 32'h6000_0000, 33});
    v.push_back('{"div_minm1", 32'h8000_0000, 32'hFFFF_FFFF, 3'd5, 32'h8000_0000, 32'h9000_0000, 33});
    foreach (v[i]) begin
      do_op(v[i].a, v[i].b, v[i].op, res, flg, lat);
      checks++;
      if (lat !== v[i].lat) begin
        errors++;
        $display("FAIL %s_lat: got=%0d required=%0d", v[i].name, lat, v[i].lat);
      end
      checks++;
      if (res !== v[i].res) begin
        errors++;
        $display("FAIL %s_res: got=%h required=%h", v[i].name, res, v[i].res);
      end
      checks++;
      if (flg !== v[i].flg) begin
        errors++;
        $display("FAIL %s_flags: got=%h required=%h", v[i].name, flg, v[i].flg);
      end
      consume();
    end
  endtask

  // Random operations issued back to back, each taken the cycle it appears.
  task automatic test_back_to_back();
    logic [31:0] a, b, res, flg, exp_res, exp_flg;
    logic [2:0]  op;
    int          lat, exp_lat;
    for (int n = 0; n < 48; n++) begin
      a  = pick();
      b  = pick();
      op = 3'($urandom_range(0, 7));
      ref_alu(a, b, op, exp_res, exp_flg);
      exp_lat = (op == 3'd4 || op == 3'd5) ? W + 1 : 1;
      do_op(a, b, op, res, flg, lat);
      checks++;
      if (lat !== exp_lat || res !== exp_res || flg !== exp_flg) begin
        errors++;
        $display("FAIL rand_op%0d a=%h b=%h: got res=%h flags=%h lat=%0d required res=%h flags=%h lat=%0d",
                 op, a, b, res, flg, lat, exp_res, exp_flg, exp_lat);
      end
      consume();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res, flg, exp_res, exp_flg;
    int          lat, bad, late;
    ref_alu(32'hDEAD_BEEF, 32'h0F0F_0F0F, 3'd7, exp_res, exp_flg);
    do_op(32'hDEAD_BEEF, 32'h0F0F_0F0F, 3'd7, res, flg, lat);
    checks++;
    if (res !== exp_res || flg !== exp_flg) begin
      errors++;
      $display("FAIL bp_result: got=%h/%h required=%h/%h", res, flg, exp_res, exp_flg);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        val_A    = 32'h0000_0001;
        val_B    = 32'h0000_0001;
        ALU_op   = 3'd0;
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (ALU_out !== exp_res || flags !== exp_flg || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d of 5 cycles unstable, last ALU_out=%h flags=%h in_ready=%b required %h/%h/0",
               bad, ALU_out, flags, in_ready, exp_res, exp_flg);
    end
    val_A    = 32'h0000_0003;
    val_B    = 32'h0000_0004;
    ALU_op   = 3'd0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    late = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) late++;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL bp_no_queue: out_valid high %0d cycles required 0", late);
    end
  endtask

  task automatic test_reset_abort();
    int spurious, busy_ready;
    logic [31:0] res, flg;
    int lat;
    val_A    = 32'h0000_1234;
    val_B    = 32'h0000_5678;
    ALU_op   = 3'd4;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    busy_ready = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_ready++;
    end
    checks++;
    if (busy_ready != 0) begin
      errors++;
      $display("FAIL busy_hs: %0d cycles with in_ready/out_valid set, required 0", busy_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || flags !== 32'd0) begin
      errors++;
      $display("FAIL abort_state: in_ready=%b out_valid=%b flags=%h required 1/0/0", in_ready, out_valid, flags);
    end
    spurious = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL abort_no_result: out_valid high %0d cycles required 0", spurious);
    end
    // Reset wins over out_ready and in_valid presented in the same cycle.
    do_op(32'h0000_0005, 32'h0000_0006, 3'd0, res, flg, lat);
    val_A     = 32'h0000_0009;
    val_B     = 32'h0000_0009;
    ALU_op    = 3'd0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || ALU_out !== 32'd0) begin
      errors++;
      $display("FAIL rst_priority: in_ready=%b out_valid=%b ALU_out=%h required 1/0/0", in_ready, out_valid, ALU_out);
    end
    spurious = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL rst_priority_quiet: out_valid high %0d cycles required 0", spurious);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    val_A     = '0;
    val_B     = '0;
    ALU_op    = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/it_alu.md
IT_ALU -- requirements
Module: it_alu

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand/result width in bits (legal values 8..64, even).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  SHALL indicate an operation is presented.
REQ-005 in_ready  output  1  SHALL indicate the block accepts an operation this cycle.
REQ-006 val_A  input  WIDTH  SHALL be operand A (two's-complement signed).
REQ-007 val_B  input  WIDTH  SHALL be operand B (two's-complement signed).
REQ-008 ALU_op  input  3  SHALL select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 DIV, 110 NOT(B), 111 XOR.
REQ-009 out_valid  output  1  SHALL indicate ALU_out/flags hold a completed result.
REQ-010 out_ready  input  1  SHALL indicate the consumer takes the result this cycle.
REQ-011 ALU_out  output  WIDTH  SHALL carry the result.
REQ-012 flags  output  32  SHALL carry bit31 N, bit30 Z, bit29 I (invalid), bit28 V (overflow); all other bits 0.

Function
REQ-013 Handshake: an operation SHALL be accepted on a rising edge where in_valid and in_ready are both 1; operands and ALU_op SHALL be captured then and later input changes SHALL have no effect.
REQ-014 FSM SHALL have states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE: on accept, ops 000/001/010/011/110/111 SHALL go to DONE (out_valid high the cycle after acceptance); ops 100/101 SHALL go to BUSY.
REQ-016 BUSY SHALL run an iterative algorithm of exactly WIDTH steps, one per cycle, then go to DONE, so out_valid rises WIDTH+1 cycles after acceptance.
REQ-017 DONE: ALU_out and flags SHALL hold stable while out_ready is 0; on out_ready=1 the FSM SHALL go to IDLE (in_ready high the following cycle; no same-cycle re-accept).
REQ-018 in_valid while in_ready=0 SHALL be ignored and SHALL not be queued.
REQ-019 ADD/SUB SHALL compute modulo 2^WIDTH; V SHALL be set on signed overflow (ADD: equal operand signs, result sign differs; SUB: operand signs differ, result sign differs from A).
REQ-020 MUL SHALL compute the signed 2*WIDTH-bit product by shift-add, output the low WIDTH bits, and set V when the high WIDTH bits are not the sign-extension of bit WIDTH-1 of the low half.
REQ-021 DIV SHALL compute the signed quotient truncated toward zero by restoring division on magnitudes with sign correction; the remainder SHALL be discarded.
REQ-022 DIV with B=0 SHALL output 0 with I=1 and still take WIDTH+1 cycles.
REQ-023 DIV of the most negative value by -1 SHALL output the most negative value with V=1.
REQ-024 AND/OR/XOR/NOT SHALL set V=0 and I=0.
REQ-025 For every op, N SHALL equal ALU_out[WIDTH-1] and Z SHALL be 1 iff ALU_out is 0.
REQ-026 I and V SHALL be 0 for all cases not named in REQ-019..REQ-023.

Reset
REQ-027 While rst=1 at a rising edge, the FSM SHALL enter IDLE with in_ready=1, out_valid=0, ALU_out=0, flags=0, and step counter=0.
REQ-028 rst during BUSY or DONE SHALL discard the operation in progress; no out_valid SHALL be produced for it.
REQ-029 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification (WIDTH=32)
REQ-030 ADD 0x7FFFFFFF + 0x00000001 accepted at cycle t -> out_valid at t+1, ALU_out 0x80000000, flags 0x90000000.
REQ-031 MUL 0xFFFFFFFD (-3) * 0x00000007 at t -> out_valid at t+33, ALU_out 0xFFFFFFEB, flags 0x80000000; MUL 0x00010000*0x00010000 -> ALU_out 0, flags 0x50000000.
REQ-032 DIV 0xFFFFFFF9 (-7) / 2 -> ALU_out 0xFFFFFFFD, flags 0x80000000; DIV 7 / 0 -> ALU_out 0, flags 0x60000000, out_valid at t+33.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> ALU_out 0x80000000, flags 0x90000000.
REQ-034 Backpressure: XOR result with out_ready=0 for 5 cycles -> ALU_out/flags stable, in_ready=0, a second in_valid ignored; out_ready=1 -> in_ready=1 next cycle.
REQ-035 rst asserted 10 cycles into a MUL -> next cycle in_ready=1, out_valid=0, flags=0; no result emitted for the aborted MUL.
